// File: rtl/int_to_float_rne_if.sv
// Valid/ready stream bundle for int_to_float_rne: integer operand in, packed float out.
// slave = converter side, master = producer/consumer side.
interface int_to_float_rne_if #(
  parameter int MANTISSA_SIZE = 23,
  parameter int EXPONENT_SIZE = 8,
  parameter int INT_SIZE      = 32
);
  localparam int FLOAT_SIZE = 1 + EXPONENT_SIZE + MANTISSA_SIZE;

  logic                  in_valid;
  logic                  in_ready;
  logic [INT_SIZE-1:0]   in;
  logic                  in_unsigned;
  logic                  out_valid;
  logic                  out_ready;
  logic [FLOAT_SIZE-1:0] out;
  logic                  out_inexact;

  modport slave (
    input  in_valid, in, in_unsigned, out_ready,
    output in_ready, out_valid, out, out_inexact
  );

  modport master (
    output in_valid, in, in_unsigned, out_ready,
    input  in_ready, out_valid, out, out_inexact
  );
endinterface

// File: rtl/int_to_float_rne.sv
// Streaming integer-to-float converter: input register, then abs / leading-one / normalise / round-pack.
// Define INT_TO_FLOAT_ROUND_NEAREST_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module int_to_float_rne #(
  parameter int MANTISSA_SIZE = 23,
  parameter int EXPONENT_SIZE = 8,
  parameter int INT_SIZE      = 32
) (
  input logic               clk,
  input logic               resetn,
  int_to_float_rne_if.slave bus
);
  localparam int FLOAT_SIZE = 1 + EXPONENT_SIZE + MANTISSA_SIZE;
  localparam int BIAS       = 2 ** (EXPONENT_SIZE - 1) - 1;
  localparam int PW         = $clog2(INT_SIZE);

  logic                     v0_q, uns0_q;
  logic [INT_SIZE-1:0]      in0_q;
  logic                     v1_q, sign1_q, sign1_d;
  logic [INT_SIZE-1:0]      mag1_q, mag1_d;
  logic                     v2_q, sign2_q, zero2_q, zero2_d;
  logic [INT_SIZE-1:0]      mag2_q;
  logic [PW-1:0]            p2_q, p2_d;
  logic                     v3_q, sign3_q, zero3_q, g3_q, g3_d, st3_q, st3_d;
  logic [PW-1:0]            p3_q;
  logic [MANTISSA_SIZE-1:0] frac3_q, frac3_d;
  logic                     out_valid_q, inexact_q, inexact_d;
  logic [FLOAT_SIZE-1:0]    out_q, out_d;
  logic                     stall, round_carry;
  logic [MANTISSA_SIZE-1:0] mant;
  logic [EXPONENT_SIZE-1:0] exp_d;
  int                       norm_sh;

  assign stall           = out_valid_q && !bus.out_ready;
  assign bus.in_ready    = resetn && !stall;
  assign bus.out_valid   = out_valid_q;
  assign bus.out         = out_q;
  assign bus.out_inexact = inexact_q;

  always_comb begin
    sign1_d = !uns0_q && in0_q[INT_SIZE-1];
    mag1_d  = sign1_d ? ('0 - in0_q) : in0_q;
  end

  always_comb begin
    zero2_d = (mag1_q == '0);
    p2_d    = '0;
    for (int unsigned i = 0; i < INT_SIZE; i++)
      if (mag1_q[i]) p2_d = PW'(i);
  end

  // The hidden bit is dropped here; only the stored fraction travels to the last stage.
  always_comb begin
    norm_sh = int'(p2_q) - MANTISSA_SIZE;
    frac3_d = '0;
    g3_d    = 1'b0;
    st3_d   = 1'b0;
    if (norm_sh <= 0) begin
      frac3_d = MANTISSA_SIZE'(mag2_q << (-norm_sh));
    end else begin
      frac3_d = MANTISSA_SIZE'(mag2_q >> norm_sh);
      g3_d    = 1'(mag2_q >> (norm_sh - 1));
      st3_d   = (mag2_q << (INT_SIZE - norm_sh + 1)) != '0;
    end
  end

`ifdef INT_TO_FLOAT_ROUND_NEAREST_EN
  logic [MANTISSA_SIZE:0] frac_sum;
  // The hidden bit is always 1, so the significand carries out exactly when the fraction overflows.
  always_comb begin
    frac_sum    = {1'b0, frac3_q} + (MANTISSA_SIZE + 1)'(g3_q && (st3_q || frac3_q[0]));
    round_carry = frac_sum[MANTISSA_SIZE];
    mant        = frac_sum[MANTISSA_SIZE-1:0];
  end
`else
  always_comb begin
    round_carry = 1'b0;
    mant        = frac3_q;
  end
`endif

  always_comb begin
    exp_d     = EXPONENT_SIZE'(p3_q) + EXPONENT_SIZE'(BIAS) + EXPONENT_SIZE'(round_carry);
    out_d     = zero3_q ? '0 : {sign3_q, exp_d, mant};
    inexact_d = g3_q || st3_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      v0_q        <= 1'b0;
      in0_q       <= '0;
      uns0_q      <= 1'b0;
      v1_q        <= 1'b0;
      sign1_q     <= 1'b0;
      mag1_q      <= '0;
      v2_q        <= 1'b0;
      sign2_q     <= 1'b0;
      zero2_q     <= 1'b0;
      mag2_q      <= '0;
      p2_q        <= '0;
      v3_q        <= 1'b0;
      sign3_q     <= 1'b0;
      zero3_q     <= 1'b0;
      p3_q        <= '0;
      frac3_q     <= '0;
      g3_q        <= 1'b0;
      st3_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      inexact_q   <= 1'b0;
    end else if (!stall) begin
      v0_q        <= bus.in_valid;
      in0_q       <= bus.in;
      uns0_q      <= bus.in_unsigned;
      v1_q        <= v0_q;
      sign1_q     <= sign1_d;
      mag1_q      <= mag1_d;
      v2_q        <= v1_q;
      sign2_q     <= sign1_q;
      zero2_q     <= zero2_d;
      mag2_q      <= mag1_q;
      p2_q        <= p2_d;
      v3_q        <= v2_q;
      sign3_q     <= sign2_q;
      zero3_q     <= zero2_q;
      p3_q        <= p2_q;
      frac3_q     <= frac3_d;
      g3_q        <= g3_d;
      st3_q       <= st3_d;
      out_valid_q <= v3_q;
      out_q       <= out_d;
      inexact_q   <= inexact_d;
    end
  end
endmodule

// File: doc/int_to_float_rne.md
# int_to_float_rne

Streaming, fully parameterised integer-to-float converter. It accepts signed or unsigned integers per transaction and packs them into an IEEE-754-style float with configurable exponent and mantissa widths. Default rounding is round-to-nearest-even, and an inexact flag is reported. It sits between integer producers (counters, vertex/fixed-point stages) and the float arithmetic units, with a valid/ready handshake on both sides so it can absorb back-pressure.

## Interface
Parameters:
- `MANTISSA_SIZE`, 23: stored mantissa bits (hidden bit excluded).
- `EXPONENT_SIZE`, 8: exponent bits. Bias is 2^(EXPONENT_SIZE-1)-1.
- `INT_SIZE`, 32: input integer width.
  - Constraint: INT_SIZE ≥ MANTISSA_SIZE+2.
  - Constraint: 2^(EXPONENT_SIZE-1)-1 > INT_SIZE, so the result can never overflow to infinity.
- `FLOAT_SIZE` (localparam): 1+EXPONENT_SIZE+MANTISSA_SIZE.

Ports:
- `clk`  in  1  clock. Everything is sampled on posedge.
- `resetn`  in  1  synchronous reset, active-low.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  converter can accept a beat.
- `in`  in  INT_SIZE  integer operand.
- `in_unsigned`  in  1  1: `in` is unsigned. 0: `in` is two's complement.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out`  out  FLOAT_SIZE  packed as {sign, exponent, mantissa}.
- `out_inexact`  out  1  result differs from the exact integer value.

## Operation
- An input transfer happens when in_valid && in_ready. An output transfer happens when out_valid && out_ready.
- Stall rule: stall = out_valid && !out_ready. While stalled, every pipeline register, including each stage's valid bit, holds its value.
- in_ready = resetn && !stall. This is combinational and has no dependency on in_valid.
- Stage 1: absolute value.
  - sign = !in_unsigned && in[INT_SIZE-1].
  - Magnitude is INT_SIZE bits wide, so the signed minimum 2^(INT_SIZE-1) is represented exactly.
- Stage 2: leading-one detect. Produces p, the index of the MSB of the magnitude. A zero magnitude sets the zero flag.
- Stage 3: normalise.
  - If p ≤ MANTISSA_SIZE: shift left by MANTISSA_SIZE-p. The result is exact, with guard=0 and sticky=0.
  - Otherwise: shift right by p-MANTISSA_SIZE.
    - guard = the bit just below the kept LSB.
    - sticky = OR of all lower bits.
- Stage 4: round and pack.
  - Round up when guard && (sticky || lsb).
  - If rounding carries out of the MANTISSA_SIZE+1-bit significand: exponent = p+bias+1 and mantissa = 0.
  - Otherwise: exponent = p+bias and mantissa = significand[MANTISSA_SIZE-1:0].
  - out_inexact = guard || sticky.
- Zero input produces +0 (all bits 0) with out_inexact=0. This holds in both modes.
- Results leave the pipeline in input order. No beat is dropped or duplicated.

## Timing
- Latency: an input accepted at edge N appears with out_valid=1 after edge N+4, provided no stall occurs in between. Each stall cycle adds one cycle.
- Throughput: one conversion per clock while out_ready=1.
- While out_valid=1 and out_ready=0, `out` and `out_inexact` stay stable until the transfer completes.
- A pipeline bubble (in_valid=0) moves through the stages as a cleared valid bit. Bubbles are not squeezed out while stalled; this is the simple global-stall design.
- Reset: on any posedge with resetn=0:
  - all stage valid bits clear;
  - out_valid=0, out=0, out_inexact=0;
  - in_ready=0 for as long as resetn is low.
- Reset mid-operation discards all in-flight beats. The first edge with resetn=1 may accept a new beat.
- Simultaneous input and output transfer in the same cycle is legal, and the pipeline advances.

## Configuration
- Macro: `INT_TO_FLOAT_ROUND_NEAREST_EN`.
- Defined: round-to-nearest-even as described in Operation.
- Undefined:
  - The pipeline is still 4 stages with the same latency and handshake.
  - The mantissa is truncated (round toward zero) and the round-up carry path is removed.
  - out_inexact is still computed as guard || sticky.

## Test plan
- Defaults, in_unsigned=0, one beat each:
  - in=1 → 0x3F800000.
  - in=-1 (0xFFFFFFFF) → 0xBF800000.
  - in=0 → 0x00000000.
  - out_inexact=0 for all three, out_valid exactly 4 cycles after acceptance.
- Signed minimum: in=0x80000000, in_unsigned=0 → 0xCF000000, inexact=0.
- Unsigned maximum: in=0xFFFFFFFF, in_unsigned=1:
  - with the macro → 0x4F800000, inexact=1;
  - without it → 0x4F7FFFFF, inexact=1.
- Tie cases:
  - 16777217 → 0x4B800000 (tie to even, rounds down), inexact=1.
  - 16777219 → 0x4B800002 with the macro, 0x4B800001 without it. Both inexact=1.
- Back-pressure:
  - Stimulus: stream 20 random beats at in_valid=1 while out_ready toggles pseudo-randomly.
  - Required: outputs match the reference model in order, and `out` is stable while stalled.
  - Required: in_ready=0 exactly when out_valid && !out_ready.
- Reset mid-stream: assert resetn=0 for 1 cycle with 3 beats in flight.
  - Required: out_valid=0 next cycle, with none of those 3 beats ever emitted.
  - Required: a beat accepted right after reset emerges 4 cycles later.
